vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_axis_counter.sv | 26 ++
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the types that carry raster position
// and sync/blank state between the timing generator and downstream stages.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_DEF    = 640;
    localparam int H_TOTAL_DEF      = 800;
    localparam int H_SYNC_START_DEF = 656;
    localparam int H_SYNC_END_DEF   = 752;
    localparam int V_VISIBLE_DEF    = 480;
    localparam int V_TOTAL_DEF      = 525;
    localparam int V_SYNC_START_DEF = 490;
    localparam int V_SYNC_END_DEF   = 492;

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               blank;
        logic [COORD_W-1:0] DrawX;
        logic [COORD_W-1:0] DrawY;
    } vga_timing_t;

    // Registered per-pixel flags, decoded one position ahead of the counters.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
        logic line_start;
        logic frame_start;
    } vga_flags_t;

    // Flag values for raster position (0,0): syncs idle, pixel visible, both pulses high.
    localparam vga_flags_t FLAGS_ORIGIN = '{hs: 1'b1, vs: 1'b1, blank: 1'b1,
                                            line_start: 1'b1, frame_start: 1'b1};

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis; wrap flags the enabled
// cycle in which the count returns from max to zero.
import vga_pkg::*;

module vga_axis_counter (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic [COORD_W-1:0] max,
    output logic [COORD_W-1:0] count,
    output logic               wrap
);

    assign wrap = en && (count == max);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical position counters plus registered
// sync, blank and start-of-line/frame flags aligned with DrawX/DrawY.
import vga_pkg::*;

module vga_timing_gen #(
    parameter int H_VISIBLE    = H_VISIBLE_DEF,
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int H_SYNC_END   = H_SYNC_END_DEF,
    parameter int V_VISIBLE    = V_VISIBLE_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int V_SYNC_END   = V_SYNC_END_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               pix_ce,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic               line_start,
    output logic               frame_start
);

    localparam logic [COORD_W-1:0] H_MAX = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_MAX = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] H_SS  = COORD_W'(H_SYNC_START);
    localparam logic [COORD_W-1:0] H_SE  = COORD_W'(H_SYNC_END);
    localparam logic [COORD_W-1:0] V_VIS = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] V_SS  = COORD_W'(V_SYNC_START);
    localparam logic [COORD_W-1:0] V_SE  = COORD_W'(V_SYNC_END);

    logic [COORD_W-1:0] hc, vc, hc_nxt, vc_nxt;
    logic               h_wrap, v_wrap, v_en;
    vga_flags_t         flags_d, flags_q;

    assign v_en = h_wrap & pix_ce;

    vga_axis_counter u_h_cnt (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .en      (pix_ce),
        .max     (H_MAX),
        .count   (hc),
        .wrap    (h_wrap)
    );

    vga_axis_counter u_v_cnt (
        .clk     (vga_clk),
        .reset_n (reset_n),
        .en      (v_en),
        .max     (V_MAX),
        .count   (vc),
        .wrap    (v_wrap)
    );

    // Position the counters move to on this enabled edge; only consumed when pix_ce=1.
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        hc_nxt = h_wrap ? '0 : hc + 1'b1;
        vc_nxt = v_wrap ? '0 : (h_wrap ? vc + 1'b1 : vc);

        flags_d             = FLAGS_ORIGIN;
        flags_d.hs          = !((hc_nxt >= H_SS) && (hc_nxt < H_SE));
        flags_d.vs          = !((vc_nxt >= V_SS) && (vc_nxt < V_SE));
        flags_d.blank       = (hc_nxt < H_VIS) && (vc_nxt < V_VIS);
        flags_d.line_start  = (hc_nxt == '0);
        flags_d.frame_start = (hc_nxt == '0) && (vc_nxt == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= FLAGS_ORIGIN;
        end else if (pix_ce) begin
            flags_q <= flags_d;
        end
    end

    assign DrawX       = hc;
    assign DrawY       = vc;
    assign hs          = flags_q.hs;
    assign vs          = flags_q.vs;
    assign blank       = flags_q.blank;
    assign line_start  = flags_q.line_start;
    assign frame_start = flags_q.frame_start;
    assign sync        = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance and a tiny
// 10x5 instance, both compared against a position model every cycle.
module tb_vga_timing_gen;

    localparam int S_HT = 10, S_VT = 5, S_HV = 6, S_VV = 3;
    localparam int S_HSS = 7, S_HSE = 9, S_VSS = 3, S_VSE = 4;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic       pix_ce, pix_ce_s;
    logic [9:0] DrawX, DrawY, sdx, sdy;
    logic       hs, vs, blank, sync, line_start, frame_start;
    logic       shs, svs, sblank, ssync, sls, sfs;

    int n_checks = 0;
    int n_errors = 0;
    int bx = 0, by = 0, sx = 0, sy = 0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .sync        (sync),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    vga_timing_gen #(
        .H_VISIBLE (S_HV), .H_TOTAL (S_HT), .H_SYNC_START (S_HSS), .H_SYNC_END (S_HSE),
        .V_VISIBLE (S_VV), .V_TOTAL (S_VT), .V_SYNC_START (S_VSS), .V_SYNC_END (S_VSE)
    ) dut_s (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .pix_ce      (pix_ce_s),
        .DrawX       (sdx),
        .DrawY       (sdy),
        .hs          (shs),
        .vs          (svs),
        .blank       (sblank),
        .sync        (ssync),
        .line_start  (sls),
        .frame_start (sfs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected {hs, vs, blank, line_start, frame_start} at position (x,y).
    function automatic logic [4:0] exp_flags(input int x, input int y, input int hv,
                                             input int hss, input int hse, input int vv,
                                             input int vss, input int vse);
        exp_flags = {!(x >= hss && x < hse), !(y >= vss && y < vse),
                     (x < hv && y < vv), (x == 0), (x == 0 && y == 0)};
    endfunction

    task automatic check_big();
        logic [4:0] f;
        f = exp_flags(bx, by, 640, 656, 752, 480, 490, 492);
        check("dx", DrawX, bx);
        check("dy", DrawY, by);
        check("hs", hs, f[4]);
        check("vs", vs, f[3]);
        check("blank", blank, f[2]);
        check("line_start", line_start, f[1]);
        check("frame_start", frame_start, f[0]);
        check("sync", sync, 0);
    endtask

    task automatic check_small();
        logic [4:0] f;
        f = exp_flags(sx, sy, S_HV, S_HSS, S_HSE, S_VV, S_VSS, S_VSE);
        check("s_dx", sdx, sx);
        check("s_dy", sdy, sy);
        check("s_hs", shs, f[4]);
        check("s_vs", svs, f[3]);
        check("s_blank", sblank, f[2]);
        check("s_line_start", sls, f[1]);
        check("s_frame_start", sfs, f[0]);
        check("s_sync", ssync, 0);
    endtask

    // One clock; models advance when their clock-enable was high at the edge.
    task automatic tick();
        logic ce, ces, rn;
        ce  = pix_ce;
        ces = pix_ce_s;
        @(posedge vga_clk);
        rn = reset_n;
        #1;
        if (rn && ce) begin
            if (bx == 799) begin
                bx = 0;
                by = (by == 524) ? 0 : by + 1;
            end else begin
                bx++;
            end
        end
        if (rn && ces) begin
            if (sx == S_HT - 1) begin
                sx = 0;
                sy = (sy == S_VT - 1) ? 0 : sy + 1;
            end else begin
                sx++;
            end
        end
    endtask

    initial begin
        int hs_low, blank_line, ls_cnt;
        int fs_cnt, sls_cnt, sblank_cnt, shs_cnt, svs_cnt;
        int n_rise, rise0, rise1;
        logic prev_fs;

        reset_n  = 1'b0;
        pix_ce   = 1'b0;
        pix_ce_s = 1'b0;
        #23;
        check_big();
        check_small();

        // Release and run continuously up to (300, 11).
        @(posedge vga_clk);
        #1;
        reset_n = 1'b1;
        pix_ce  = 1'b1;
        hs_low     = hs ? 0 : 1;
        blank_line = blank ? 1 : 0;
        ls_cnt     = 0;
        for (int i = 1; i <= 9100; i++) begin
            tick();
            check_big();
            if (i == 1) check("first_x", DrawX, 1);
            if (i == 800) begin
                check("ls_800", line_start, 1);
                check("dy_800", DrawY, 1);
            end
            if (by == 10 && bx == 639) check("blank_639", blank, 1);
            if (by == 10 && bx == 640) check("blank_640", blank, 0);
            if (by == 10 && bx == 655) check("hs_655", hs, 1);
            if (by == 10 && bx == 656) check("hs_656", hs, 0);
            if (by == 10 && bx == 751) check("hs_751", hs, 0);
            if (by == 10 && bx == 752) check("hs_752", hs, 1);
            if (bx == 0) begin
                check("hs_low_line", hs_low, 96);
                check("blank_line", blank_line, 640);
                hs_low     = 0;
                blank_line = 0;
                ls_cnt++;
            end
            if (!hs) hs_low++;
            if (blank) blank_line++;
        end
        check("ls_count", ls_cnt, 11);

        // Gapped enable: counters and flags hold on idle cycles.
        for (int i = 0; i < 40; i++) begin
            pix_ce = (i % 2 == 0);
            tick();
            check_big();
        end
        check("gap_x", DrawX, 320);

        // Asynchronous reset in the middle of a cycle, then resume from origin.
        pix_ce = 1'b1;
        #3;
        reset_n = 1'b0;
        bx = 0;
        by = 0;
        #1;
        check_big();
        check("rst_line_start", line_start, 1);
        tick();
        tick();
        check_big();
        reset_n = 1'b1;
        tick();
        check("resume_x", DrawX, 1);
        check("resume_y", DrawY, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_big();
        end

        // Small instance: two continuous frames, including the last-pixel wrap.
        pix_ce   = 1'b0;
        pix_ce_s = 1'b1;
        fs_cnt = 0; sls_cnt = 0; sblank_cnt = 0; shs_cnt = 0; svs_cnt = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            check_small();
            check_big();
            if (i == 50) begin
                check("s_wrap_fs", sfs, 1);
                check("s_wrap_blank", sblank, 1);
            end
            if (sfs) fs_cnt++;
            if (sls) sls_cnt++;
            if (sblank) sblank_cnt++;
            if (!shs) shs_cnt++;
            if (!svs) svs_cnt++;
        end
        check("s_fs_count", fs_cnt, 2);
        check("s_ls_count", sls_cnt, 10);
        check("s_blank_count", sblank_cnt, 36);
        check("s_hs_low_count", shs_cnt, 20);
        check("s_vs_low_count", svs_cnt, 20);

        // Small instance, 1010 enable: frame takes 100 clocks, pulses stretch.
        n_rise  = 0;
        rise0   = -1;
        rise1   = -1;
        prev_fs = sfs;
        for (int i = 0; i < 220; i++) begin
            pix_ce_s = (i % 2 == 0);
            tick();
            check_small();
            if (sfs && !prev_fs) begin
                if (n_rise == 0) rise0 = i;
                else if (n_rise == 1) rise1 = i;
                n_rise++;
            end
            prev_fs = sfs;
        end
        check("s_fs_rises", n_rise, 2);
        check("s_frame_len", rise1 - rise0, 100);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
